// File: rtl/logic_gate_unit.sv
// logic_gate_unit
//   Two-stage elastic pipeline that applies one of eight bitwise operations
//   to a pair of WIDTH-bit operands. Each result carries zero/parity flags,
//   and a saturating counter tracks completed output handshakes.
//
// Ports:
//   clk           rising-edge clock
//   reset_n       asynchronous active-low reset
//   input_a/b     operands (WIDTH bits)
//   op            operation select, captured with the operands
//                 000 AND, 001 OR, 010 XOR, 011 NAND,
//                 100 NOR, 101 XNOR, 110 NOT A, 111 PASS A
//   in_valid      operands/op valid
//   in_ready      unit can accept this cycle (combinational from out_ready)
//   result        registered operation result
//   result_zero   result == 0
//   result_parity XOR-reduce of result
//   out_valid     result/flags valid
//   out_ready     consumer accepts this cycle
//   count_clr     synchronous clear of op_count (wins over a handshake)
//   op_count      completed output handshakes, saturating
module logic_gate_unit #(
  parameter int WIDTH   = 8,
  parameter int COUNT_W = 16
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic [WIDTH-1:0]   input_a,
  input  logic [WIDTH-1:0]   input_b,
  input  logic [2:0]         op,
  input  logic               in_valid,
  output logic               in_ready,
  output logic [WIDTH-1:0]   result,
  output logic               result_zero,
  output logic               result_parity,
  output logic               out_valid,
  input  logic               out_ready,
  input  logic               count_clr,
  output logic [COUNT_W-1:0] op_count
);

  // Stage 1: captured operands and op
  logic [WIDTH-1:0]   s1_a_q, s1_a_d;
  logic [WIDTH-1:0]   s1_b_q, s1_b_d;
  logic [2:0]         s1_op_q, s1_op_d;
  logic               s1_valid_q, s1_valid_d;

  // Stage 2: result and flags
  logic [WIDTH-1:0]   result_q, result_d;
  logic               zero_q, zero_d;
  logic               parity_q, parity_d;
  logic               s2_valid_q, s2_valid_d;

  logic [COUNT_W-1:0] count_q, count_d;

  logic               s2_free;
  logic               s1_adv;
  logic               in_fire;
  logic               out_fire;
  logic [WIDTH-1:0]   op_res;

  // Handshake network. in_ready looks through stage 2 so a full pipe keeps
  // streaming at one transaction per cycle while the consumer is ready.
  always_comb begin
    s2_free  = !s2_valid_q || out_ready;
    s1_adv   = s1_valid_q && s2_free;
    in_ready = !s1_valid_q || s2_free;
    in_fire  = in_valid && in_ready;
    out_fire = s2_valid_q && out_ready;
  end

  // Bitwise operation on stage-1 data
  always_comb begin
    op_res = '0;
    case (s1_op_q)
      3'b000: op_res = s1_a_q & s1_b_q;
      3'b001: op_res = s1_a_q | s1_b_q;
      3'b010: op_res = s1_a_q ^ s1_b_q;
      3'b011: op_res = ~(s1_a_q & s1_b_q);
      3'b100: op_res = ~(s1_a_q | s1_b_q);
      3'b101: op_res = ~(s1_a_q ^ s1_b_q);
      3'b110: op_res = ~s1_a_q;
      3'b111: op_res = s1_a_q;
    endcase
  end

  // Next-state logic
  always_comb begin
    s1_a_d     = s1_a_q;
    s1_b_d     = s1_b_q;
    s1_op_d    = s1_op_q;
    s1_valid_d = s1_valid_q;
    result_d   = result_q;
    zero_d     = zero_q;
    parity_d   = parity_q;
    s2_valid_d = s2_valid_q;
    count_d    = count_q;

    // Stage 1 loads on input handshake, empties when it hands off with
    // nothing new arriving.
    if (in_fire) begin
      s1_a_d     = input_a;
      s1_b_d     = input_b;
      s1_op_d    = op;
      s1_valid_d = 1'b1;
    end else if (s1_adv) begin
      s1_valid_d = 1'b0;
    end

    // Stage 2 only updates on an advance, so the output holds during a stall.
    if (s1_adv) begin
      result_d   = op_res;
      zero_d     = (op_res == '0);
      parity_d   = ^op_res;
      s2_valid_d = 1'b1;
    end else if (out_ready) begin
      s2_valid_d = 1'b0;
    end

    if (count_clr) begin
      count_d = '0;
    end else if (out_fire && (count_q != {COUNT_W{1'b1}})) begin
      count_d = count_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      s1_a_q     <= '0;
      s1_b_q     <= '0;
      s1_op_q    <= '0;
      s1_valid_q <= 1'b0;
      result_q   <= '0;
      zero_q     <= 1'b0;
      parity_q   <= 1'b0;
      s2_valid_q <= 1'b0;
      count_q    <= '0;
    end else begin
      s1_a_q     <= s1_a_d;
      s1_b_q     <= s1_b_d;
      s1_op_q    <= s1_op_d;
      s1_valid_q <= s1_valid_d;
      result_q   <= result_d;
      zero_q     <= zero_d;
      parity_q   <= parity_d;
      s2_valid_q <= s2_valid_d;
      count_q    <= count_d;
    end
  end

  assign result        = result_q;
  assign result_zero   = zero_q;
  assign result_parity = parity_q;
  assign out_valid     = s2_valid_q;
  assign op_count      = count_q;

endmodule

// File: tb/tb_logic_gate_unit.sv
// Directed bench for logic_gate_unit. A second instance with COUNT_W=2
// shares every input so counter saturation is exercised by the same traffic.
module tb_logic_gate_unit;

  logic        clk;
  logic        reset_n;
  logic [7:0]  input_a;
  logic [7:0]  input_b;
  logic [2:0]  op;
  logic        in_valid;
  logic        out_ready;
  logic        count_clr;

  logic        in_ready;
  logic [7:0]  result;
  logic        result_zero;
  logic        result_parity;
  logic        out_valid;
  logic [15:0] op_count;

  logic        in_ready_c;
  logic [7:0]  result_c;
  logic        result_zero_c;
  logic        result_parity_c;
  logic        out_valid_c;
  logic [1:0]  op_count_c;

  int checks = 0;
  int errors = 0;

  logic [7:0] exp_ops [8] = '{8'hC0, 8'hFC, 8'h3C, 8'h3F, 8'h03, 8'hC3, 8'h0F, 8'hF0};

  logic_gate_unit #(.WIDTH(8), .COUNT_W(16)) u_dut (
    .clk(clk), .reset_n(reset_n), .input_a(input_a), .input_b(input_b),
    .op(op), .in_valid(in_valid), .in_ready(in_ready), .result(result),
    .result_zero(result_zero), .result_parity(result_parity),
    .out_valid(out_valid), .out_ready(out_ready), .count_clr(count_clr),
    .op_count(op_count)
  );

  logic_gate_unit #(.WIDTH(8), .COUNT_W(2)) u_dut_c (
    .clk(clk), .reset_n(reset_n), .input_a(input_a), .input_b(input_b),
    .op(op), .in_valid(in_valid), .in_ready(in_ready_c), .result(result_c),
    .result_zero(result_zero_c), .result_parity(result_parity_c),
    .out_valid(out_valid_c), .out_ready(out_ready), .count_clr(count_clr),
    .op_count(op_count_c)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
    $display("check %-16s observed=0x%0h expected=0x%0h", tag, obs, exp);
  endtask

  // One transaction into an idle unit with out_ready high; checks latency,
  // result and flags, then lets the output drain.
  task automatic run_single(input string tag, input logic [7:0] a, input logic [7:0] b,
                            input logic [2:0] o, input logic [7:0] exp_res,
                            input logic exp_zero, input logic exp_par);
    int lat;
    input_a   = a;
    input_b   = b;
    op        = o;
    in_valid  = 1'b1;
    out_ready = 1'b1;
    step();
    in_valid = 1'b0;
    lat = 1;
    while (!out_valid && lat < 6) begin
      step();
      lat++;
    end
    chk({tag, "_lat"}, lat, 2);
    chk({tag, "_res"}, {24'h0, result}, {24'h0, exp_res});
    chk({tag, "_zero"}, {31'h0, result_zero}, {31'h0, exp_zero});
    chk({tag, "_par"}, {31'h0, result_parity}, {31'h0, exp_par});
    step();
  endtask

  initial begin
    int sent, recv, cyc;
    logic hs_in, hs_out, stalled;
    logic [7:0] held;

    reset_n   = 1'b0;
    input_a   = '0;
    input_b   = '0;
    op        = '0;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    count_clr = 1'b0;

    // 1. Reset / idle
    step();
    chk("rst_out_valid", {31'h0, out_valid}, 0);
    chk("rst_result", {24'h0, result}, 0);
    step();
    step();
    reset_n = 1'b1;
    step();
    chk("idle_out_valid", {31'h0, out_valid}, 0);
    chk("idle_result", {24'h0, result}, 0);
    chk("idle_op_count", {16'h0, op_count}, 0);
    chk("idle_in_ready", {31'h0, in_ready}, 1);

    // 2. All ops back-to-back, A=F0 B=CC
    input_a = 8'hF0;
    input_b = 8'hCC;
    for (int i = 0; i < 10; i++) begin
      in_valid = (i < 8);
      op       = 3'(i);
      step();
      if (i == 0) begin
        chk("ops_lat_early", {31'h0, out_valid}, 0);
      end else if (i <= 8) begin
        chk($sformatf("ops_valid_%0d", i - 1), {31'h0, out_valid}, 1);
        chk($sformatf("ops_res_%0d", i - 1), {24'h0, result}, {24'h0, exp_ops[i-1]});
        chk($sformatf("ops_par_%0d", i - 1), {31'h0, result_parity}, 0);
        chk($sformatf("ops_resc_%0d", i - 1), {24'h0, result_c}, {24'h0, exp_ops[i-1]});
      end
    end
    chk("ops_drained", {31'h0, out_valid}, 0);
    chk("ops_count", {16'h0, op_count}, 8);
    chk("ops_count_sat", {30'h0, op_count_c}, 3);

    // 3. Flags
    run_single("xor_zero", 8'hAA, 8'hAA, 3'b010, 8'h00, 1'b1, 1'b0);
    run_single("pass_par", 8'h01, 8'h77, 3'b111, 8'h01, 1'b0, 1'b1);
    chk("flag_count", {16'h0, op_count}, 10);

    count_clr = 1'b1;
    step();
    count_clr = 1'b0;
    chk("clr_count", {16'h0, op_count}, 0);
    chk("clr_count_c", {30'h0, op_count_c}, 0);

    // 4. Backpressure: 5 PASS transactions, consumer stalls cycles 2..5.
    // Operands offered while in_ready is low are garbage and must be ignored.
    sent = 0;
    recv = 0;
    cyc  = 0;
    op      = 3'b111;
    input_b = 8'h00;
    while (recv < 5 && cyc < 30) begin
      out_ready = !(cyc >= 2 && cyc <= 5);
      #1;
      if (cyc >= 2 && cyc <= 5) chk($sformatf("bp_in_ready_%0d", cyc), {31'h0, in_ready}, 0);
      in_valid = (sent < 5);
      input_a  = in_ready ? 8'(8'h10 + sent) : 8'hEE;
      hs_in    = in_valid && in_ready;
      hs_out   = out_valid && out_ready;
      stalled  = out_valid && !out_ready;
      held     = result;
      if (hs_out) begin
        chk($sformatf("bp_order_%0d", recv), {24'h0, result}, 32'(8'h10 + recv));
        recv++;
      end
      step();
      if (stalled) chk($sformatf("bp_hold_%0d", cyc), {24'h0, result}, {24'h0, held});
      if (hs_in) sent++;
      cyc++;
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    chk("bp_recv", recv, 5);
    chk("bp_count", {16'h0, op_count}, 5);
    chk("bp_count_sat", {30'h0, op_count_c}, 3);
    step();
    chk("bp_no_dup", {31'h0, out_valid}, 0);

    // 5. count_clr wins over a simultaneous handshake
    input_a   = 8'h5A;
    op        = 3'b111;
    in_valid  = 1'b1;
    out_ready = 1'b0;
    step();
    in_valid = 1'b0;
    step();
    chk("clr_pre_valid", {31'h0, out_valid}, 1);
    out_ready = 1'b1;
    count_clr = 1'b1;
    step();
    count_clr = 1'b0;
    chk("clr_hs_count", {16'h0, op_count}, 0);
    chk("clr_hs_count_c", {30'h0, op_count_c}, 0);
    chk("clr_hs_drained", {31'h0, out_valid}, 0);

    // 6. Async reset with two transactions in flight
    op       = 3'b111;
    input_a  = 8'h33;
    in_valid = 1'b1;
    step();
    input_a = 8'h44;
    step();
    in_valid = 1'b0;
    chk("ar_pre_valid", {31'h0, out_valid}, 1);
    chk("ar_pre_result", {24'h0, result}, 32'h33);
    #3;
    reset_n = 1'b0;
    #1;
    chk("ar_valid_now", {31'h0, out_valid}, 0);
    chk("ar_result_now", {24'h0, result}, 0);
    step();
    step();
    reset_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      chk($sformatf("ar_no_stale_%0d", i), {31'h0, out_valid}, 0);
    end
    chk("ar_count", {16'h0, op_count}, 0);
    run_single("ar_nand", 8'h0F, 8'h3C, 3'b011, 8'hF3, 1'b0, 1'b0);
    run_single("ar_nor", 8'h0F, 8'h30, 3'b100, 8'hC0, 1'b0, 1'b0);
    chk("ar_post_count", {16'h0, op_count}, 2);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
